// File: rtl/rem_acc_pkg.sv
`default_nettype none
// ============================================================================
// rem_acc_pkg : shared types and limits for the sequential remainder engine
// Revision    : 1.0
// ============================================================================
package rem_acc_pkg;

  typedef enum logic {
    OP_LOAD = 1'b0,
    OP_REM  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

endpackage
`default_nettype wire

// File: rtl/rem_acc_step.sv
`default_nettype none
// ============================================================================
// rem_acc_step : one combinational restoring-remainder step
// Revision     : 1.0
// ============================================================================
module rem_acc_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem
);

  logic [WIDTH+1:0] w_p;
  logic             w_ge;

  assign w_p  = {i_rem, i_bit};
  assign w_ge = (w_p >= {2'b00, i_divisor});
  // When the compare succeeds the difference is below the divisor, so the
  // low WIDTH+1 bits of the subtraction are exact.
  assign o_rem = w_ge ? (w_p[WIDTH:0] - {1'b0, i_divisor}) : w_p[WIDTH:0];

endmodule
`default_nettype wire

// File: rtl/rem_acc_seq.sv
`default_nettype none
// ============================================================================
// rem_acc_seq : multi-cycle accumulator remainder engine (acc %= operand)
// Revision    : 1.0
// ============================================================================
module rem_acc_seq
  import rem_acc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_dz,
  output logic             busy
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("rem_acc_seq: WIDTH out of legal range");
  end

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH:0]   w_rem_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;
  logic             r_dz;
  logic             w_is_rem;
  logic             w_opd_zero;
  logic             w_last;
  logic             w_acc_neg;
  logic             w_opd_neg;
  logic [WIDTH-1:0] w_acc_mag;
  logic [WIDTH-1:0] w_opd_mag;

  assign w_is_rem   = (op_e'(in_op) == OP_REM);
  assign w_opd_zero = (in_operand == '0);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  // Magnitudes are unsigned WIDTH-bit, so |most-negative| still fits.
  assign w_acc_neg = in_signed && r_acc[WIDTH-1];
  assign w_opd_neg = in_signed && in_operand[WIDTH-1];
  assign w_acc_mag = w_acc_neg ? (~r_acc + 1'b1) : r_acc;
  assign w_opd_mag = w_opd_neg ? (~in_operand + 1'b1) : in_operand;

  rem_acc_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = (w_is_rem && !w_opd_zero) ? CALC : RESP;
        end
      end
      CALC: begin
        if (w_last) begin
          w_state_nxt = FIX;
        end
      end
      FIX: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_dz  <= 1'b0;
      r_dvd <= '0;
      r_dvs <= '0;
      r_rem <= '0;
      r_cnt <= '0;
      r_neg <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (!w_is_rem) begin
              r_acc <= in_operand;
              r_dz  <= 1'b0;
            end else if (w_opd_zero) begin
              r_dz  <= 1'b1;
            end else begin
              r_dvd <= w_acc_mag;
              r_dvs <= w_opd_mag;
              r_neg <= w_acc_neg;
              r_rem <= '0;
              r_cnt <= '0;
              r_dz  <= 1'b0;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
        end
        FIX: begin
          // Remainder takes the dividend's sign.
          r_acc <= r_neg ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == RESP);
  assign out_acc   = r_acc;
  assign out_dz    = r_dz;

endmodule
`default_nettype wire
